// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier over a little-endian byte stream.
// Optional MUL_SEQ_OVERFLOW_EN adds a sticky overflow_o using a double-width partial product.
module mul_seq #(
    parameter int unsigned datawidth_p = 8,
    parameter int unsigned opwidth_p   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [datawidth_p-1:0] data_i,
    output logic                   ready_o,
    input  logic [15:0]            len_i,
    input  logic                   start_i,
    output logic                   done_o,
`ifdef MUL_SEQ_OVERFLOW_EN
    output logic                   overflow_o,
`endif
    output logic [opwidth_p-1:0]   result_o
);

    localparam int unsigned BPO = opwidth_p / datawidth_p;
    localparam int unsigned CW  = $clog2(opwidth_p);
`ifdef MUL_SEQ_OVERFLOW_EN
    localparam int unsigned PW  = 2 * opwidth_p;
`else
    localparam int unsigned PW  = opwidth_p;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          nops_q, nops_d;
    logic [15:0]          ntail_q, ntail_d;
    logic [15:0]          opcnt_q, opcnt_d;
    logic [15:0]          beatcnt_q, beatcnt_d;
    logic [opwidth_p-1:0] op_q, op_d;
    logic [opwidth_p-1:0] acc_q, acc_d;
    logic [PW-1:0]        partial_q, partial_d;
    logic [CW-1:0]        bitcnt_q, bitcnt_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic [opwidth_p-1:0] result_q, result_d;

    logic [15:0]          len_nops;
    logic [15:0]          len_tail;
    logic                 hs;
    logic [PW-1:0]        partial_sum;

    assign len_nops    = len_i / 16'(BPO);
    assign len_tail    = len_i % 16'(BPO);
    assign hs          = valid_i && ready_q;
    assign partial_sum = op_q[bitcnt_q] ? (partial_q + (PW'(acc_q) << bitcnt_q)) : partial_q;

`ifdef MUL_SEQ_OVERFLOW_EN
    logic sticky_q, sticky_d;
    logic ovf_q, ovf_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            nops_q    <= '0;
            ntail_q   <= '0;
            opcnt_q   <= '0;
            beatcnt_q <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            partial_q <= '0;
            bitcnt_q  <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
`ifdef MUL_SEQ_OVERFLOW_EN
            sticky_q  <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            nops_q    <= nops_d;
            ntail_q   <= ntail_d;
            opcnt_q   <= opcnt_d;
            beatcnt_q <= beatcnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            partial_q <= partial_d;
            bitcnt_q  <= bitcnt_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            result_q  <= result_d;
`ifdef MUL_SEQ_OVERFLOW_EN
            sticky_q  <= sticky_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        nops_d    = nops_q;
        ntail_d   = ntail_q;
        opcnt_d   = opcnt_q;
        beatcnt_d = beatcnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        partial_d = partial_q;
        bitcnt_d  = bitcnt_q;
        result_d  = result_q;
`ifdef MUL_SEQ_OVERFLOW_EN
        sticky_d  = sticky_q;
        ovf_d     = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    nops_d    = len_nops;
                    ntail_d   = len_tail;
                    acc_d     = opwidth_p'(1);
                    opcnt_d   = '0;
                    beatcnt_d = '0;
`ifdef MUL_SEQ_OVERFLOW_EN
                    sticky_d  = 1'b0;
                    ovf_d     = 1'b0;
`endif
                    if (len_nops != 16'd0) begin
                        state_d = LOAD;
                    end else if (len_tail != 16'd0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d  = DONE;
                        result_d = opwidth_p'(1);
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    // Shift in from the top so the first beat lands in the LSBs
                    op_d = {data_i, op_q[opwidth_p-1:datawidth_p]};
                    if (beatcnt_q == 16'(BPO - 1)) begin
                        beatcnt_d = '0;
                        partial_d = '0;
                        bitcnt_d  = '0;
                        state_d   = MUL;
                    end else begin
                        beatcnt_d = beatcnt_q + 16'd1;
                    end
                end
            end
            MUL: begin
                partial_d = partial_sum;
                bitcnt_d  = bitcnt_q + CW'(1);
                if (bitcnt_q == CW'(opwidth_p - 1)) begin
                    acc_d   = partial_sum[opwidth_p-1:0];
                    opcnt_d = opcnt_q + 16'd1;
`ifdef MUL_SEQ_OVERFLOW_EN
                    sticky_d = sticky_q | (|partial_sum[PW-1:opwidth_p]);
                    ovf_d    = sticky_d;
`endif
                    if (opcnt_q + 16'd1 < nops_q) begin
                        state_d = LOAD;
                    end else if (ntail_q != 16'd0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d  = DONE;
                        result_d = partial_sum[opwidth_p-1:0];
                    end
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (beatcnt_q == ntail_q - 16'd1) begin
                        beatcnt_d = '0;
                        state_d   = DONE;
                        result_d  = acc_q;
                    end else begin
                        beatcnt_d = beatcnt_q + 16'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == LOAD) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    assign ready_o  = ready_q;
    assign done_o   = done_q;
    assign result_o = result_q;
`ifdef MUL_SEQ_OVERFLOW_EN
    assign overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: directed and random payloads against a plain-arithmetic product model.
module tb_mul_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        ready_o;
    logic [15:0] len_i = '0;
    logic        start_i = 1'b0;
    logic        done_o;
    logic [31:0] result_o;
    logic        overflow_w;

    mul_seq dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .len_i    (len_i),
        .start_i  (start_i),
        .done_o   (done_o),
`ifdef MUL_SEQ_OVERFLOW_EN
        .overflow_o (overflow_w),
`endif
        .result_o (result_o)
    );

`ifndef MUL_SEQ_OVERFLOW_EN
    assign overflow_w = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: every done pulse pops one expected result
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", 64'(result_o), 64'(e.res));
`ifdef MUL_SEQ_OVERFLOW_EN
                chk("overflow", 64'(overflow_w), 64'(e.ovf));
`endif
            end
        end
    end

    // Reference: product of whole little-endian operands, tail bytes ignored
    function automatic exp_t model(input int unsigned len, input logic [7:0] b[$]);
        exp_t        e;
        logic [31:0] acc;
        logic [63:0] prod;
        logic [31:0] op;
        acc   = 32'd1;
        e.ovf = 1'b0;
        for (int k = 0; k < int'(len / 4); k++) begin
            op   = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
            prod = 64'(acc) * 64'(op);
            if (prod[63:32] != 32'd0) e.ovf = 1'b1;
            acc = prod[31:0];
        end
        e.res = acc;
        return e;
    endfunction

    task automatic run_txn(input int unsigned len, input logic [7:0] b[$],
                           input int gap_pct, input bit restart);
        int          idx;
        int          guard;
        int          start_cyc;
        int          last_hs;
        int          exp_cyc;
        int          mul_start;
        int          ready_bad;
        int          ready_seen;
        bit          restarted;
        exp_t        e;
        e = model(len, b);
        exp_q.push_back(e);
        idx = 0; guard = 0; ready_bad = 0; ready_seen = 0; restarted = 0;
        mul_start = -100;
        @(negedge clk_i);
        start_i = 1'b1;
        len_i   = 16'(len);
        start_cyc = cyc;
        last_hs   = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        while (idx < int'(len) && guard < 5000) begin
            if (cyc > mul_start && cyc <= mul_start + 32 && ready_o) ready_bad++;
            if (ready_o) ready_seen++;
            if (restart && !restarted && idx == 2) begin
                start_i   = 1'b1;
                len_i     = 16'd4;
                restarted = 1'b1;
            end
            if ($urandom_range(99) < gap_pct) begin
                valid_i = 1'b0;
            end else begin
                valid_i = 1'b1;
                data_i  = b[idx];
            end
            if (valid_i && ready_o) begin
                last_hs = cyc;
                idx++;
                if (idx % 4 == 0 && idx <= int'(len / 4) * 4) mul_start = cyc;
            end
            @(negedge clk_i);
            start_i = 1'b0;
            valid_i = 1'b0;
            guard++;
        end
        chk("beats_accepted", 64'(idx), 64'(len));
        guard = 0;
        while (!done_o && guard < 200) begin
            if (cyc > mul_start && cyc <= mul_start + 32 && ready_o) ready_bad++;
            if (ready_o) ready_seen++;
            @(negedge clk_i);
            guard++;
        end
        if (len % 4 != 0) exp_cyc = last_hs + 1;
        else if (len != 0) exp_cyc = last_hs + 33;
        else exp_cyc = start_cyc + 1;
        chk("done_seen", 64'(done_o), 64'd1);
        chk("done_latency", 64'(cyc), 64'(exp_cyc));
        chk("ready_low_in_mul", 64'(ready_bad), 64'd0);
        if (len == 0) chk("ready_never_len0", 64'(ready_seen), 64'd0);
        @(negedge clk_i);
        chk("done_single_cycle", 64'(done_o), 64'd0);
        chk("result_held", 64'(result_o), 64'(e.res));
    endtask

    initial begin
        logic [7:0] b[$];
        int unsigned len;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_overflow", 64'(overflow_w), 64'd0);
        rst_i = 1'b0;

        b = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        run_txn(8, b, 0, 0);
        b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        run_txn(8, b, 0, 0);
        b = {};
        run_txn(0, b, 0, 0);
        b = '{8'h07, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        run_txn(6, b, 0, 0);
        b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
              8'h07, 8'h00, 8'h00, 8'h00};
        run_txn(12, b, 40, 1);
        chk("restart_ignored_result", 64'(result_o), 64'h2A);

        // Asynchronous reset during MUL aborts without a done pulse
        @(negedge clk_i);
        start_i = 1'b1; len_i = 16'd8;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = 8'h11;
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_ready", 64'(ready_o), 64'd0);
        chk("async_rst_done", 64'(done_o), 64'd0);
        chk("async_rst_result", 64'(result_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        chk("no_done_after_abort", 64'(exp_q.size()), 64'd0);
        b = '{8'h09, 8'h00, 8'h00, 8'h00};
        run_txn(4, b, 0, 0);

        for (int t = 0; t < 16; t++) begin
            len = $urandom_range(14);
            b = {};
            for (int i = 0; i < int'(len); i++) begin
                if ($urandom_range(1) == 0) b.push_back(8'($urandom_range(9)));
                else b.push_back(8'($urandom));
            end
            run_txn(len, b, 25, 0);
        end

        repeat (5) @(negedge clk_i);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
